// File: rtl/spi_adc_ctrl.sv
// spi_adc_ctrl: single-frame SPI ADC read sequencer (CPOL=1, MSB first).
// Frames one read per start (or per quiet period in continuous mode), divides
// clk down to SCLK, and presents the low DATA_BITS of the frame with a done strobe.
module spi_adc_ctrl #(
    parameter int unsigned DIV        = 10,
    parameter int unsigned FRAME_BITS = 16,
    parameter int unsigned DATA_BITS  = 12,
    parameter int unsigned QUIET_CYC  = 20
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 cont,
    input  logic                 sdata,
    output logic                 cs_n,
    output logic                 sclk,
    output logic                 busy,
    output logic                 done,
    output logic [DATA_BITS-1:0] data
);

    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W   = $clog2(FRAME_BITS + 1);
    localparam int unsigned QUIET_W = (QUIET_CYC > 0) ? $clog2(QUIET_CYC + 1) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(FRAME_BITS);
    localparam logic [QUIET_W-1:0] QUIET_LAST = QUIET_W'(QUIET_CYC);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        QUIET
    } state_e;

    state_e                state_q, state_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [QUIET_W-1:0]    quiet_cnt_q, quiet_cnt_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  cs_n_q, cs_n_d;
    logic                  sclk_q, sclk_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic div_last;
    assign div_last = (div_cnt_q == DIV_LAST);

    // Next-state and registered-output logic for the frame sequencer.
    always_comb begin
        state_d     = state_q;
        div_cnt_d   = div_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        quiet_cnt_d = quiet_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        cs_n_d      = cs_n_q;
        sclk_d      = sclk_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                cs_n_d = 1'b1;
                sclk_d = 1'b1;
                busy_d = 1'b0;
                if (start) begin
                    state_d   = CS_SETUP;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                end
            end
            CS_SETUP: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    sclk_d    = 1'b0;
                    state_d   = SHIFT;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            SHIFT: begin
                // After the final rising edge SCLK is left high for one more
                // half-period; the would-be falling edge hands over to CS_HOLD.
                if (div_last) begin
                    div_cnt_d = '0;
                    if (!sclk_q) begin
                        sclk_d    = 1'b1;
                        shift_d   = {shift_q[FRAME_BITS-2:0], sdata};
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end else if (bit_cnt_q == BIT_LAST) begin
                        state_d = CS_HOLD;
                    end else begin
                        sclk_d = 1'b0;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            CS_HOLD: begin
                if (div_last) begin
                    div_cnt_d   = '0;
                    cs_n_d      = 1'b1;
                    data_d      = shift_q[DATA_BITS-1:0];
                    done_d      = 1'b1;
                    quiet_cnt_d = '0;
                    state_d     = QUIET;
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            QUIET: begin
                if (quiet_cnt_q == QUIET_LAST) begin
                    quiet_cnt_d = '0;
                    if (cont) begin
                        state_d   = CS_SETUP;
                        cs_n_d    = 1'b0;
                        div_cnt_d = '0;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    quiet_cnt_d = quiet_cnt_q + QUIET_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counters and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            quiet_cnt_q <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            quiet_cnt_q <= quiet_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cs_n = cs_n_q;
    assign sclk = sclk_q;
    assign busy = busy_q;
    assign done = done_q;
    assign data = data_q;

endmodule
